semaforo_ctrl: RTL and testbench

Sequencing controller that drives the traffic-light block's command side and reads back its lamp outputs. It generates the free-running millisecond timebase `CHRONO`, issues single-cycle `CHANGE` requests when the red or green dwell time expires, and debounces a pedestrian push-button that shortens green. It monitors the `GREEN`/`YELLOW`/`RED` feedback to detect stuck or illegal lamp states.

---
 rtl/semaforo_pkg.sv | 26 ++
 rtl/semaforo_ctrl_debounce.sv | 44 ++++
 rtl/semaforo_ctrl.sv | 165 ++++++++++++++++
 tb/tb_semaforo_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared lamp codes, controller state encoding and lamp-code helper for the
// traffic-light sequencing controller.
package semaforo_pkg;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DWELL_R,
    ST_DWELL_G,
    ST_REQ,
    ST_LEAVE,
    ST_WAIT_Y,
    ST_FAULT
  } state_t;

  // More than one lamp lit at once can never be a real light state.
  function automatic logic lamp_illegal(input logic [2:0] code);
    return (code[0] & code[1]) | (code[0] & code[2]) | (code[1] & code[2]);
  endfunction

endpackage

// File: rtl/semaforo_ctrl_debounce.sv
// Pedestrian button conditioning: two-flop synchronizer followed by a stable-time
// counter that advances only on millisecond ticks.
module debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  // Any sample agreeing with the accepted level restarts the stable-time count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light sequencer: millisecond timebase, red/green dwell timing with a
// pedestrian shortcut, and supervision of the lamp feedback.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned RED_MS      = 8000,
  parameter int unsigned GREEN_MS    = 10000,
  parameter int unsigned PED_MS      = 2000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_MS  = 5000,
  parameter logic [31:0] CHRONO_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        BTN,
  input  logic        GREEN,
  input  logic        YELLOW,
  input  logic        RED,
  output logic [31:0] CHRONO,
  output logic        CHANGE,
  output logic        PED_WALK,
  output logic        FAULT
);

  localparam int unsigned   PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [31:0]   RED_LIM    = 32'(RED_MS);
  localparam logic [31:0]   GREEN_LIM  = 32'(GREEN_MS);
  localparam logic [31:0]   PED_LIM    = 32'(PED_MS);
  localparam logic [31:0]   TO_LIM     = 32'(TIMEOUT_MS);

  logic [PW-1:0] presc;
  logic          tick;
  logic [2:0]    lamp;
  state_t        state_q;
  state_t        state_d;
  logic [31:0]   t_start;
  logic [31:0]   elapsed;
  logic [31:0]   green_limit;
  logic [31:0]   ped_limit;
  logic          ped_pending;
  logic          ped_latched;
  logic          btn_level;
  logic          btn_level_q;

  assign lamp      = {GREEN, YELLOW, RED};
  assign tick      = (presc == PRESC_LAST);
  assign elapsed   = CHRONO - t_start;
  assign ped_limit = elapsed + PED_LIM;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc  <= '0;
      CHRONO <= CHRONO_INIT;
    end else if (tick) begin
      presc  <= '0;
      CHRONO <= CHRONO + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_debounce (
    .clk  (CLK),
    .rst  (RST),
    .tick (tick),
    .btn  (BTN),
    .level(btn_level)
  );

  // Global supervision rules take priority over the per-state sequencing.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_FAULT) begin
      state_d = ST_FAULT;
    end else if (!EN) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE && lamp_illegal(lamp)) begin
      state_d = ST_FAULT;
    end else if (lamp == LAMP_OFF && !(state_q inside {ST_IDLE, ST_SYNC})) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (lamp == LAMP_RED)         state_d = ST_DWELL_R;
          else if (lamp == LAMP_GREEN)  state_d = ST_DWELL_G;
          else if (lamp == LAMP_YELLOW) state_d = ST_WAIT_Y;
          else if (elapsed >= TO_LIM)   state_d = ST_FAULT;
        end
        ST_DWELL_R: begin
          if (elapsed >= RED_LIM) state_d = ST_REQ;
        end
        ST_DWELL_G: begin
          if (elapsed >= green_limit) state_d = ST_REQ;
        end
        ST_REQ: state_d = ST_LEAVE;
        ST_LEAVE: begin
          if (lamp == LAMP_YELLOW)    state_d = ST_WAIT_Y;
          else if (elapsed >= TO_LIM) state_d = ST_FAULT;
        end
        ST_WAIT_Y: begin
          if (lamp == LAMP_RED)         state_d = ST_DWELL_R;
          else if (lamp == LAMP_GREEN)  state_d = ST_DWELL_G;
          else if (elapsed >= TO_LIM)   state_d = ST_FAULT;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // Outputs decode the upcoming state so they are registered yet aligned with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      t_start  <= '0;
      CHANGE   <= 1'b0;
      PED_WALK <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      state_q  <= state_d;
      CHANGE   <= (state_d == ST_REQ);
      PED_WALK <= (state_d == ST_DWELL_R);
      FAULT    <= (state_d == ST_FAULT);
      if (state_d != state_q) begin
        t_start <= CHRONO;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_level_q <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      btn_level_q <= btn_level;
      if (state_q inside {ST_IDLE, ST_DWELL_R}) begin
        ped_pending <= 1'b0;
      end else if (btn_level && !btn_level_q) begin
        ped_pending <= 1'b1;
      end
    end
  end

  // The pedestrian shortcut is applied once per green and can only shorten it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      green_limit <= GREEN_LIM;
      ped_latched <= 1'b0;
    end else if (state_d == ST_DWELL_G && state_q != ST_DWELL_G) begin
      green_limit <= GREEN_LIM;
      ped_latched <= 1'b0;
    end else if (state_q == ST_DWELL_G && ped_pending && !ped_latched) begin
      ped_latched <= 1'b1;
      if (ped_limit < green_limit) begin
        green_limit <= ped_limit;
      end
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl with millisecond timing scaled down; a second
// instance starts its timebase just below the 32-bit wrap.
module tb_semaforo_ctrl;
  import semaforo_pkg::*;

  localparam int unsigned CLKS    = 4;
  localparam int unsigned RED_T   = 80;
  localparam int unsigned GREEN_T = 100;
  localparam int unsigned PED_T   = 20;
  localparam int unsigned DEB_T   = 5;
  localparam int unsigned TO_T    = 50;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic        btn  = 1'b0;
  logic [2:0]  lamp = 3'b000;
  logic [31:0] chrono;
  logic        change, ped_walk, fault;

  logic        rst2  = 1'b1;
  logic        en2   = 1'b0;
  logic [2:0]  lamp2 = 3'b000;
  logic [31:0] chrono2;
  logic        change2, ped_walk2, fault2;

  int checks;
  int failures;

  always #5 clk = ~clk;

  semaforo_ctrl #(
    .CLKS_PER_MS(CLKS), .RED_MS(RED_T), .GREEN_MS(GREEN_T), .PED_MS(PED_T),
    .DEBOUNCE_MS(DEB_T), .TIMEOUT_MS(TO_T), .CHRONO_INIT(32'h0000_0000)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .BTN(btn),
    .GREEN(lamp[2]), .YELLOW(lamp[1]), .RED(lamp[0]),
    .CHRONO(chrono), .CHANGE(change), .PED_WALK(ped_walk), .FAULT(fault)
  );

  semaforo_ctrl #(
    .CLKS_PER_MS(CLKS), .RED_MS(RED_T), .GREEN_MS(GREEN_T), .PED_MS(PED_T),
    .DEBOUNCE_MS(DEB_T), .TIMEOUT_MS(TO_T), .CHRONO_INIT(32'hFFFF_FFF0)
  ) dut_wrap (
    .CLK(clk), .RST(rst2), .EN(en2), .BTN(1'b0),
    .GREEN(lamp2[2]), .YELLOW(lamp2[1]), .RED(lamp2[0]),
    .CHRONO(chrono2), .CHANGE(change2), .PED_WALK(ped_walk2), .FAULT(fault2)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_change(input bit second, input int max_cycles,
                             output bit seen, output logic [31:0] at);
    seen = 1'b0;
    at   = '0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if ((second ? change2 : change) === 1'b1) begin
        seen = 1'b1;
        at   = second ? chrono2 : chrono;
        break;
      end
    end
  endtask

  task automatic wait_fault(input int max_cycles, output bit seen, output logic [31:0] at);
    seen = 1'b0;
    at   = '0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (fault === 1'b1) begin
        seen = 1'b1;
        at   = chrono;
        break;
      end
    end
  endtask

  task automatic next_ms(input bit second);
    logic [31:0] c0;
    c0 = second ? chrono2 : chrono;
    for (int i = 0; i < 4 * CLKS; i++) begin
      @(negedge clk);
      if ((second ? chrono2 : chrono) != c0) break;
    end
  endtask

  task automatic wait_chrono(input bit second, input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((second ? chrono2 : chrono) == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; btn = 1'b0; lamp = LAMP_OFF;
    repeat (3) @(negedge clk);
    checks++;
    if (chrono !== 32'd0) begin failures++; $display("[TB] FAIL reset_chrono: got %0d expected 0", chrono); end
    checks++;
    if (change !== 1'b0) begin failures++; $display("[TB] FAIL reset_change: got %b expected 0", change); end
    checks++;
    if (ped_walk !== 1'b0) begin failures++; $display("[TB] FAIL reset_walk: got %b expected 0", ped_walk); end
    checks++;
    if (fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
  endtask

  task automatic test_red_dwell();
    bit seen;
    logic [31:0] at;
    rst = 1'b0; en = 1'b1; lamp = LAMP_RED;
    repeat (2) @(negedge clk);
    checks++;
    if (ped_walk !== 1'b1) begin failures++; $display("[TB] FAIL red_walk: got %b expected 1", ped_walk); end
    wait_change(1'b0, 500, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL red_change_seen: got %b expected 1", seen); end
    checks++;
    if (at !== 32'(RED_T)) begin failures++; $display("[TB] FAIL red_change_chrono: got %0d expected %0d", at, RED_T); end
    checks++;
    if (ped_walk !== 1'b0) begin failures++; $display("[TB] FAIL red_walk_drop: got %b expected 0", ped_walk); end
    @(negedge clk);
    checks++;
    if (change !== 1'b0) begin failures++; $display("[TB] FAIL red_pulse_width: got %b expected 0", change); end
  endtask

  task automatic test_green_dwell();
    bit seen;
    logic [31:0] at, s;
    lamp = LAMP_YELLOW;
    next_ms(1'b0);
    lamp = LAMP_GREEN;
    s = chrono;
    repeat (2) @(negedge clk);
    checks++;
    if (ped_walk !== 1'b0) begin failures++; $display("[TB] FAIL green_walk: got %b expected 0", ped_walk); end
    wait_change(1'b0, 600, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL green_change_seen: got %b expected 1", seen); end
    checks++;
    if (at !== s + 32'(GREEN_T)) begin
      failures++; $display("[TB] FAIL green_change_chrono: got %0d expected %0d", at, s + 32'(GREEN_T));
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0) begin failures++; $display("[TB] FAIL green_pulse_width: got %b expected 0", change); end
  endtask

  task automatic test_ped_button();
    bit seen, ok, all_ok;
    logic [31:0] at, r, s;
    lamp = LAMP_YELLOW;
    next_ms(1'b0);
    lamp = LAMP_RED;
    r = chrono;
    wait_change(1'b0, 500, seen, at);
    checks++;
    if (at !== r + 32'(RED_T)) begin
      failures++; $display("[TB] FAIL ped_red_chrono: got %0d expected %0d", at, r + 32'(RED_T));
    end
    @(negedge clk);
    lamp = LAMP_YELLOW;
    next_ms(1'b0);
    lamp = LAMP_GREEN;
    s = chrono;
    // Press at +30 ms, bounce each ms, settle high from +34 ms.
    all_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_chrono(1'b0, s + 32'(30 + k), ok);
      all_ok &= ok;
      btn = (k % 2 == 0);
    end
    checks++;
    if (all_ok !== 1'b1) begin failures++; $display("[TB] FAIL ped_bounce_timing: got %b expected 1", all_ok); end
    wait_change(1'b0, 600, seen, at);
    btn = 1'b0;
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ped_change_seen: got %b expected 1", seen); end
    checks++;
    if (at !== s + 32'(34 + DEB_T + PED_T)) begin
      failures++; $display("[TB] FAIL ped_change_chrono: got %0d expected %0d", at, s + 32'(34 + DEB_T + PED_T));
    end
    @(negedge clk);
    checks++;
    if (change !== 1'b0) begin failures++; $display("[TB] FAIL ped_pulse_width: got %b expected 0", change); end
  endtask

  task automatic test_stuck_lamp();
    bit seen;
    logic [31:0] at, q;
    int highs;
    lamp = LAMP_YELLOW;
    next_ms(1'b0);
    lamp = LAMP_RED;
    wait_change(1'b0, 500, seen, q);
    wait_fault(500, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL stuck_fault_seen: got %b expected 1", seen); end
    checks++;
    if (at !== q + 32'(TO_T)) begin
      failures++; $display("[TB] FAIL stuck_fault_chrono: got %0d expected %0d", at, q + 32'(TO_T));
    end
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (change !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin failures++; $display("[TB] FAIL stuck_change_quiet: got %0d high cycles expected 0", highs); end
    checks++;
    if (fault !== 1'b1) begin failures++; $display("[TB] FAIL stuck_fault_hold: got %b expected 1", fault); end
  endtask

  task automatic test_illegal_code();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; lamp = LAMP_RED;
    repeat (5) @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin failures++; $display("[TB] FAIL illegal_pre_fault: got %b expected 0", fault); end
    lamp = 3'b110;
    @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin failures++; $display("[TB] FAIL illegal_fault: got %b expected 1", fault); end
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin failures++; $display("[TB] FAIL illegal_fault_sticky: got %b expected 1", fault); end
    rst = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0) begin failures++; $display("[TB] FAIL illegal_rst_fault: got %b expected 0", fault); end
    checks++;
    if (chrono !== 32'd0) begin failures++; $display("[TB] FAIL illegal_rst_chrono: got %0d expected 0", chrono); end
    checks++;
    if (change !== 1'b0 || ped_walk !== 1'b0) begin
      failures++; $display("[TB] FAIL illegal_rst_outputs: got change=%b walk=%b expected 0 0", change, ped_walk);
    end
  endtask

  task automatic test_sync_timeout();
    bit seen;
    logic [31:0] at;
    en = 1'b0; lamp = LAMP_OFF;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    wait_fault(500, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL sync_fault_seen: got %b expected 1", seen); end
    checks++;
    if (at !== 32'(TO_T)) begin failures++; $display("[TB] FAIL sync_fault_chrono: got %0d expected %0d", at, TO_T); end
  endtask

  task automatic test_wrap_and_disable();
    bit seen, ok;
    logic [31:0] at, r, c;
    int highs;
    rst2 = 1'b0; en2 = 1'b1; lamp2 = LAMP_RED;
    @(negedge clk);
    checks++;
    if (chrono2 !== 32'hFFFF_FFF0) begin failures++; $display("[TB] FAIL wrap_init: got %h expected fffffff0", chrono2); end
    wait_change(1'b1, 500, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL wrap_change_seen: got %b expected 1", seen); end
    checks++;
    if (at !== 32'h0000_0040) begin failures++; $display("[TB] FAIL wrap_change_chrono: got %h expected 00000040", at); end
    @(negedge clk);
    lamp2 = LAMP_YELLOW;
    next_ms(1'b1);
    lamp2 = LAMP_RED;
    r = chrono2;
    wait_chrono(1'b1, r + 32'd10, ok);
    checks++;
    if (ok !== 1'b1 || ped_walk2 !== 1'b1) begin
      failures++; $display("[TB] FAIL disable_pre_walk: got ok=%b walk=%b expected 1 1", ok, ped_walk2);
    end
    en2 = 1'b0;
    c = chrono2;
    @(negedge clk);
    checks++;
    if (ped_walk2 !== 1'b0 || change2 !== 1'b0) begin
      failures++; $display("[TB] FAIL disable_outputs: got walk=%b change=%b expected 0 0", ped_walk2, change2);
    end
    repeat (39) @(negedge clk);
    checks++;
    if (chrono2 !== c + 32'd10) begin failures++; $display("[TB] FAIL disable_chrono_runs: got %0d expected %0d", chrono2, c + 32'd10); end
    highs = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (change2 !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin failures++; $display("[TB] FAIL disable_change_quiet: got %0d high cycles expected 0", highs); end
    en2 = 1'b1;
    wait_change(1'b1, 500, seen, at);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("[TB] FAIL reenable_change_seen: got %b expected 1", seen); end
    rst2 = 1'b1;
    #1;
    checks++;
    if (change2 !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_pulse: got %b expected 0", change2); end
    checks++;
    if (chrono2 !== 32'hFFFF_FFF0) begin failures++; $display("[TB] FAIL rst_mid_pulse_chrono: got %h expected fffffff0", chrono2); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_red_dwell();
    test_green_dwell();
    test_ped_button();
    test_stuck_lamp();
    test_illegal_code();
    test_sync_timeout();
    test_wrap_and_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
